mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_pkg.sv | 68 ++++++
 rtl/mem_access_unit_load_align.sv | 39 +++
 rtl/mem_access_unit.sv | 146 ++++++++++++++
 tb/tb_mem_access_unit.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage data-memory access unit.
//   - data width, default ack timeout
//   - Funct3 load/store size encodings
//   - FSM state encoding
//   - helpers for access size, alignment and store lane formatting
package mem_access_unit_pkg;

    localparam int DATA_W          = 32;
    localparam int TIMEOUT_DEFAULT = 255;

    // Funct3 encodings shared by loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mau_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } access_size_e;

    // Unrecognised Funct3 values behave as word accesses.
    function automatic access_size_e access_size(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: return SZ_BYTE;
            F3_H, F3_HU: return SZ_HALF;
            default:     return SZ_WORD;
        endcase
    endfunction

    function automatic logic access_misaligned(input logic [2:0] funct3,
                                               input logic [1:0] offset);
        case (access_size(funct3))
            SZ_HALF: return offset[0];
            SZ_WORD: return offset != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_strb(input logic [2:0] funct3,
                                              input logic [1:0] offset);
        case (access_size(funct3))
            SZ_BYTE: return 4'b0001 << offset;
            SZ_HALF: return 4'b0011 << offset;
            default: return 4'b1111;
        endcase
    endfunction

    // Sub-word stores replicate the value across all lanes; the strobe
    // picks which lanes the memory actually writes.
    function automatic logic [DATA_W-1:0] store_wdata(input logic [2:0]        funct3,
                                                      input logic [DATA_W-1:0] data);
        case (access_size(funct3))
            SZ_BYTE: return {4{data[7:0]}};
            SZ_HALF: return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// load_align: combinational byte/half extraction and sign/zero extension
// of a read data word.
//   rdata  : raw 32-bit word from data memory
//   offset : address bits [1:0] of the access
//   funct3 : load size/sign (LB, LH, LW, LBU, LHU; others act as LW)
//   data   : aligned, extended result
module load_align
    import mem_access_unit_pkg::*;
(
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        offset,
    input  logic [2:0]        funct3,
    output logic [DATA_W-1:0] data
);

    logic [7:0]               byte_lane;
    logic [15:0]              half_lane;
    logic signed [7:0]        byte_s;
    logic signed [15:0]       half_s;
    logic signed [DATA_W-1:0] byte_sx;
    logic signed [DATA_W-1:0] half_sx;

    always_comb begin
        byte_lane = 8'(rdata >> {offset, 3'b000});
        half_lane = 16'(rdata >> {offset[1], 4'b0000});
        byte_s    = byte_lane;
        half_s    = half_lane;
        byte_sx   = DATA_W'(byte_s);
        half_sx   = DATA_W'(half_s);
        case (funct3)
            F3_B:    data = byte_sx;
            F3_BU:   data = DATA_W'(byte_lane);
            F3_H:    data = half_sx;
            F3_HU:   data = DATA_W'(half_lane);
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory access controller.
// Issues one bus transaction per load/store held in EX/MEM, stalls the
// front of the pipeline while the transaction is outstanding, and hands
// the write-back value to MEM/WB.
//   clk, rst                : clock, synchronous active-high reset
//   ALURes_in, StoreData_in : address / ALU result and store data
//   Rd_in, Funct3_in        : destination register, access size/sign
//   MemRead_in .. MemtoReg_in : control bits from EX/MEM
//   stall_out               : freezes PC, IF/ID, ID/EX, EX/MEM
//   WBData_out, Rd_out, RegWrite_out : values for MEM/WB
//   dmem_*                  : data-memory request / response bus
//   misalign_out, bus_err_out : one-cycle exception pulses
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] ALURes_in,
    input  logic [DATA_W-1:0] StoreData_in,
    input  logic [4:0]        Rd_in,
    input  logic [2:0]        Funct3_in,
    input  logic              MemRead_in,
    input  logic              MemWrite_in,
    input  logic              RegWrite_in,
    input  logic              MemtoReg_in,
    output logic              stall_out,
    output logic [DATA_W-1:0] WBData_out,
    output logic [4:0]        Rd_out,
    output logic              RegWrite_out,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [3:0]        dmem_wstrb,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              misalign_out,
    output logic              bus_err_out
);

    // Abort fires on the BUSY cycle whose count reaches TIMEOUT-1, so the
    // request is held for exactly TIMEOUT cycles.
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT - 1);

    mau_state_e        state;
    mau_state_e        next_state;
    logic [7:0]        wait_cnt;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] aligned_rdata;
    logic              bus_err_q;
    logic              is_access;
    logic              is_misaligned;
    logic              in_idle;
    logic              in_busy;
    logic              in_done;
    logic              start;
    logic              timeout_hit;

    // EX/MEM is frozen while stalled, so the live offset/Funct3 still
    // describe the outstanding access when the ack arrives.
    load_align u_load_align (
        .rdata  (dmem_rdata),
        .offset (ALURes_in[1:0]),
        .funct3 (Funct3_in),
        .data   (aligned_rdata)
    );

    always_comb begin
        is_access     = MemRead_in | MemWrite_in;
        is_misaligned = access_misaligned(Funct3_in, ALURes_in[1:0]);
        in_idle       = (state == ST_IDLE);
        in_busy       = (state == ST_BUSY);
        in_done       = (state == ST_DONE);
        start         = in_idle && is_access && !is_misaligned;
        timeout_hit   = in_busy && !dmem_ack && (wait_cnt == TIMEOUT_CNT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (start) next_state = ST_BUSY;
            ST_BUSY: if (dmem_ack || timeout_hit) next_state = ST_DONE;
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Bus request registers, wait counter and captured load data
    always_ff @(posedge clk) begin
        if (rst) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_wstrb <= '0;
            load_data  <= '0;
            wait_cnt   <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            bus_err_q <= timeout_hit;
            if (start) begin
                // Both MemRead and MemWrite set is handled as a store.
                dmem_req   <= 1'b1;
                dmem_we    <= MemWrite_in;
                dmem_addr  <= {ALURes_in[DATA_W-1:2], 2'b00};
                dmem_wdata <= MemWrite_in ? store_wdata(Funct3_in, StoreData_in) : '0;
                dmem_wstrb <= MemWrite_in ? store_strb(Funct3_in, ALURes_in[1:0]) : 4'b0000;
                wait_cnt   <= '0;
            end else if (in_busy) begin
                if (dmem_ack) begin
                    load_data  <= aligned_rdata;
                    dmem_req   <= 1'b0;
                    dmem_we    <= 1'b0;
                    dmem_wstrb <= 4'b0000;
                end else if (timeout_hit) begin
                    dmem_req   <= 1'b0;
                    dmem_we    <= 1'b0;
                    dmem_wstrb <= 4'b0000;
                end else begin
                    wait_cnt <= wait_cnt + 8'd1;
                end
            end
        end
    end

    always_comb begin
        stall_out    = !rst && (start || in_busy);
        misalign_out = !rst && in_idle && is_access && is_misaligned;
        bus_err_out  = !rst && bus_err_q;
        WBData_out   = (in_done && MemtoReg_in) ? load_data : ALURes_in;
        Rd_out       = Rd_in;
        RegWrite_out = !rst && RegWrite_in && !stall_out && !misalign_out
                       && !(in_done && bus_err_q);
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    localparam int TB_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ALURes_in, StoreData_in;
    logic [4:0]  Rd_in;
    logic [2:0]  Funct3_in;
    logic        MemRead_in, MemWrite_in, RegWrite_in, MemtoReg_in;
    logic        stall_out;
    logic [31:0] WBData_out;
    logic [4:0]  Rd_out;
    logic        RegWrite_out;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        misalign_out, bus_err_out;

    mem_access_unit #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .ALURes_in(ALURes_in), .StoreData_in(StoreData_in),
        .Rd_in(Rd_in), .Funct3_in(Funct3_in),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
        .stall_out(stall_out), .WBData_out(WBData_out),
        .Rd_out(Rd_out), .RegWrite_out(RegWrite_out),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .misalign_out(misalign_out), .bus_err_out(bus_err_out)
    );

    always #5 clk = ~clk;

    // Expected outputs for one clock cycle
    typedef struct {
        string       name;
        logic        stall, req, chk_req, regw, mis, berr;
        logic        chk_bus, chk_wdata, chk_wb;
        logic        we;
        logic [31:0] addr, wdata, wb;
        logic [3:0]  wstrb;
        logic [4:0]  rd;
    } exp_t;

    exp_t expq[$];
    exp_t cur;
    int   n_checks = 0;
    int   n_fail   = 0;

    // ---------------- behavioural model ----------------
    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] word);
        int unsigned b, h;
        b = (word >> (8 * off)) & 32'hFF;
        h = (word >> (16 * off[1])) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 128) ? b - 256 : b;
            3'b100:  return b;
            3'b001:  return (h >= 32768) ? h - 65536 : h;
            3'b101:  return h;
            default: return word;
        endcase
    endfunction

    function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'b000:  return 4'(1 << off);
            3'b001:  return 4'(3 << off);
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
        case (f3)
            3'b000:  return (sd & 32'hFF) * 32'h0101_0101;
            3'b001:  return (sd & 32'hFFFF) * 32'h0001_0001;
            default: return sd;
        endcase
    endfunction

    function automatic bit m_mis(input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'b000 || f3 == 3'b100) return 1'b0;
        if (f3 == 3'b001 || f3 == 3'b101) return (a % 2) != 0;
        return (a % 4) != 0;
    endfunction

    function automatic exp_t blank(input string nm, input logic [31:0] alu, input logic [4:0] rd);
        exp_t e;
        e.name = nm;  e.stall = 0; e.req = 0; e.chk_req = 1; e.regw = 0;
        e.mis = 0;    e.berr = 0;  e.chk_bus = 0; e.chk_wdata = 0; e.chk_wb = 1;
        e.we = 0;     e.addr = 0;  e.wdata = 0; e.wb = alu; e.wstrb = 0; e.rd = rd;
        return e;
    endfunction

    // ---------------- compare process ----------------
    task automatic chk(input string nm, input string field,
                       input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s t=%0t actual=%h required=%h", nm, field, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (expq.size() != 0) begin
            cur = expq.pop_front();
            chk(cur.name, "stall",    32'(stall_out),    32'(cur.stall));
            chk(cur.name, "regwrite", 32'(RegWrite_out), 32'(cur.regw));
            chk(cur.name, "misalign", 32'(misalign_out), 32'(cur.mis));
            chk(cur.name, "bus_err",  32'(bus_err_out),  32'(cur.berr));
            chk(cur.name, "rd",       32'(Rd_out),       32'(cur.rd));
            if (cur.chk_req) chk(cur.name, "req", 32'(dmem_req), 32'(cur.req));
            if (cur.chk_wb)  chk(cur.name, "wbdata", WBData_out, cur.wb);
            if (cur.chk_bus) begin
                chk(cur.name, "we",   32'(dmem_we), 32'(cur.we));
                chk(cur.name, "addr", dmem_addr,    cur.addr);
            end
            if (cur.chk_wdata) begin
                chk(cur.name, "wdata", dmem_wdata,        cur.wdata);
                chk(cur.name, "wstrb", 32'(dmem_wstrb),   32'(cur.wstrb));
            end
        end
    end

    // ---------------- driver ----------------
    task automatic cyc(input exp_t e);
        expq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_op(input string nm, input logic [31:0] alu, input logic rw,
                           input logic [4:0] rd, input logic ack);
        exp_t e;
        ALURes_in = alu; StoreData_in = 0; Funct3_in = 3'b010; Rd_in = rd;
        MemRead_in = 0; MemWrite_in = 0; RegWrite_in = rw; MemtoReg_in = 0;
        dmem_ack = ack;
        e = blank(nm, alu, rd);
        e.regw = rw;
        cyc(e);
        dmem_ack = 0;
    endtask

    // waits < 0: memory never acks. use_lit: hand-computed values replace the model.
    task automatic mem_op(input string nm, input logic rd_en, input logic wr_en,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [31:0] rdata,
                          input int waits, input logic m2r, input logic rw,
                          input logic [4:0] rd, input bit use_lit,
                          input logic [31:0] lit_wb, input logic [31:0] lit_wdata,
                          input logic [3:0] lit_wstrb);
        exp_t e;
        bit   timed_out;
        int   busy_n;
        ALURes_in = addr; StoreData_in = sdata; Funct3_in = f3; Rd_in = rd;
        MemRead_in = rd_en; MemWrite_in = wr_en; RegWrite_in = rw; MemtoReg_in = m2r;
        dmem_rdata = rdata; dmem_ack = 0;
        if (m_mis(f3, addr)) begin
            e = blank({nm, "_mis"}, addr, rd);
            e.mis = 1;
            cyc(e);
            return;
        end
        timed_out = (waits < 0);
        busy_n    = timed_out ? TB_TIMEOUT : waits + 1;
        e = blank({nm, "_issue"}, addr, rd);
        e.stall = 1;
        cyc(e);
        for (int k = 1; k <= busy_n; k++) begin
            dmem_ack = !timed_out && (k == busy_n);
            e = blank({nm, "_busy"}, addr, rd);
            e.stall = 1; e.req = 1; e.chk_bus = 1;
            e.we = wr_en; e.addr = addr & 32'hFFFF_FFFC;
            if (wr_en) begin
                e.chk_wdata = 1;
                e.wdata = use_lit ? lit_wdata : m_wdata(f3, sdata);
                e.wstrb = use_lit ? lit_wstrb : m_strb(f3, addr[1:0]);
            end
            cyc(e);
        end
        dmem_ack = 0;
        e = blank({nm, "_done"}, addr, rd);
        e.berr = timed_out;
        e.regw = rw && !timed_out;
        if (m2r) begin
            if (timed_out) e.chk_wb = 0;
            else e.wb = use_lit ? lit_wb : m_load(f3, addr[1:0], rdata);
        end
        cyc(e);
    endtask

    initial begin
        exp_t e;
        rst = 1; dmem_ack = 0; dmem_rdata = 0;
        // An aligned load is presented throughout reset: no stall may appear.
        ALURes_in = 32'h100; StoreData_in = 0; Funct3_in = 3'b010; Rd_in = 0;
        MemRead_in = 1; MemWrite_in = 0; RegWrite_in = 0; MemtoReg_in = 1;
        @(posedge clk); #1;
        e = blank("reset", 32'h100, 0);
        e.chk_bus = 1; e.chk_wdata = 1;
        cyc(e);
        rst = 0;
        MemRead_in = 0; MemtoReg_in = 0;
        e = blank("post_reset", 32'h100, 0);
        e.chk_bus = 1; e.chk_wdata = 1;
        cyc(e);

        idle_op("alu_op", 32'hDEAD_BEEF, 1, 5'd7, 0);
        idle_op("alu_norw", 32'h0000_1234, 0, 5'd3, 0);

        // Loads
        mem_op("lw_0wait", 1, 0, 3'b010, 32'h100, 0, 32'hCAFE_F00D, 0, 1, 1, 5'd1, 1, 32'hCAFE_F00D, 0, 0);
        idle_op("gap1", 32'h1, 0, 5'd0, 0);
        mem_op("lw_1wait", 1, 0, 3'b010, 32'h100, 0, 32'h1357_9BDF, 1, 1, 1, 5'd2, 0, 0, 0, 0);
        mem_op("lb_103", 1, 0, 3'b000, 32'h103, 0, 32'h80FF_FF7F, 0, 1, 1, 5'd3, 1, 32'hFFFF_FF80, 0, 0);
        mem_op("lbu_103", 1, 0, 3'b100, 32'h103, 0, 32'h80FF_FF7F, 0, 1, 1, 5'd4, 1, 32'h0000_0080, 0, 0);
        mem_op("lb_100", 1, 0, 3'b000, 32'h100, 0, 32'h80FF_FF7F, 0, 1, 1, 5'd4, 0, 0, 0, 0);
        mem_op("lh_102", 1, 0, 3'b001, 32'h102, 0, 32'h8001_1234, 0, 1, 1, 5'd5, 1, 32'hFFFF_8001, 0, 0);
        mem_op("lhu_102", 1, 0, 3'b101, 32'h102, 0, 32'h8001_1234, 1, 1, 1, 5'd6, 1, 32'h0000_8001, 0, 0);
        mem_op("lh_100", 1, 0, 3'b001, 32'h100, 0, 32'h8001_F234, 0, 1, 1, 5'd6, 0, 0, 0, 0);
        mem_op("f3_011_as_lw", 1, 0, 3'b011, 32'h104, 0, 32'hA5A5_0F0F, 0, 1, 1, 5'd8, 0, 0, 0, 0);
        mem_op("lw_nomem2reg", 1, 0, 3'b010, 32'h110, 0, 32'h7777_7777, 0, 0, 1, 5'd9, 0, 0, 0, 0);

        // Stores
        mem_op("sh_102", 0, 1, 3'b001, 32'h102, 32'h1234_ABCD, 0, 0, 0, 0, 5'd0, 1, 0, 32'hABCD_ABCD, 4'b1100);
        mem_op("sb_101", 0, 1, 3'b000, 32'h101, 32'h0000_00A5, 0, 1, 0, 0, 5'd0, 1, 0, 32'hA5A5_A5A5, 4'b0010);
        mem_op("sw_108", 0, 1, 3'b010, 32'h108, 32'h0123_4567, 0, 0, 0, 0, 5'd0, 0, 0, 0, 0);
        mem_op("rdwr_is_store", 1, 1, 3'b010, 32'h10C, 32'h89AB_CDEF, 32'h5555_5555, 0, 0, 0, 5'd0, 0, 0, 0, 0);

        // Misaligned accesses: one-cycle pulse, no request, no write-back
        mem_op("lw_101", 1, 0, 3'b010, 32'h101, 0, 0, 0, 1, 1, 5'd10, 0, 0, 0, 0);
        idle_op("after_mis", 32'h2, 1, 5'd11, 0);
        mem_op("lh_103", 1, 0, 3'b001, 32'h103, 0, 0, 0, 1, 1, 5'd12, 0, 0, 0, 0);
        mem_op("sw_102", 0, 1, 3'b010, 32'h102, 32'hFFFF_FFFF, 0, 0, 0, 1, 5'd13, 0, 0, 0, 0);
        idle_op("after_mis2", 32'h3, 0, 5'd0, 0);

        // Timeout with no ack
        mem_op("lw_timeout", 1, 0, 3'b010, 32'h200, 0, 32'hBAD0_BAD0, -1, 1, 1, 5'd14, 0, 0, 0, 0);
        idle_op("after_to", 32'h4, 1, 5'd15, 0);

        // Stray ack while idle is ignored
        idle_op("stray_ack", 32'h5, 1, 5'd16, 1);
        idle_op("after_stray", 32'h6, 0, 5'd0, 0);

        // Reset while BUSY, followed by a late ack
        ALURes_in = 32'h300; Funct3_in = 3'b010; MemRead_in = 1; MemWrite_in = 0;
        RegWrite_in = 1; MemtoReg_in = 1; Rd_in = 5'd9; dmem_rdata = 32'h1111_2222;
        e = blank("rstbusy_issue", 32'h300, 5'd9);
        e.stall = 1;
        cyc(e);
        e = blank("rstbusy_busy", 32'h300, 5'd9);
        e.stall = 1; e.req = 1; e.chk_bus = 1; e.addr = 32'h300;
        cyc(e);
        rst = 1; MemRead_in = 0; RegWrite_in = 0; MemtoReg_in = 0; ALURes_in = 0; Rd_in = 0;
        e = blank("rstbusy_rst", 32'h0, 5'd0);
        e.chk_req = 0;
        cyc(e);
        rst = 0; dmem_ack = 1; ALURes_in = 32'h55; MemtoReg_in = 1;
        e = blank("rstbusy_lateack", 32'h55, 5'd0);
        cyc(e);
        dmem_ack = 0; MemtoReg_in = 0;
        e = blank("rstbusy_after", 32'h55, 5'd0);
        cyc(e);
        mem_op("lw_after_rst", 1, 0, 3'b010, 32'h304, 0, 32'h2468_ACE0, 0, 1, 1, 5'd17, 0, 0, 0, 0);
        idle_op("final", 32'h0, 0, 5'd0, 0);

        @(negedge clk);
        #1;
        n_checks++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d required=0", expq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time=%0t required=finish", $time);
        $fatal(1, "watchdog");
    end

endmodule
